qic117_report_scheduler: RTL
============================

QIC117_REPORT_SCHEDULER -- requirements
Module: qic117_report_scheduler

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 200_000_000, system clock frequency.
REQ-002 SHALL have parameter HOLDOFF_US, default 100, minimum idle gap between consecutive reports in µs; HOLDOFF_CLKS = (CLK_FREQ_HZ/1_000_000)*HOLDOFF_US.
REQ-003 SHALL have parameter START_TIMEOUT_CLKS, default 16, maximum cycles from start pulse to encoder busy.
REQ-004 clk  input  1  system clock; all logic on posedge clk.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  tape mode active; low clears all state, same effect as reset except the error flag is held.
REQ-007 req  input  5  report request pulses; bit0 status, bit1 vendor, bit2 model, bit3 ROM version, bit4 drive config.
REQ-008 abort  input  1  one-cycle pulse; cancels the in-flight report and all pending requests.
REQ-009 clear_err  input  1  clears start_timeout_err.
REQ-010 enc_busy  input  1  status encoder busy flag.
REQ-011 enc_start  output  5  one-hot, one-cycle start pulses to the encoder, same bit mapping as req.
REQ-012 enc_enable  output  1  encoder enable.
REQ-013 done  output  1  one-cycle pulse when a report completes normally.
REQ-014 done_id  output  3  index (0-4) of the completed report; valid with done.
REQ-015 pending  output  5  outstanding request bitmap.
REQ-016 active  output  1  high in every state except IDLE.
REQ-017 start_timeout_err  output  1  sticky flag: encoder failed to accept a start.

Function
REQ-018 SHALL register all outputs.
REQ-019 SHALL update pending each cycle as (pending | req) with the bit granted this cycle cleared; a req bit set in the same cycle its pending bit is cleared SHALL leave that bit set (set wins).
REQ-020 SHALL implement states IDLE, START, WAIT_BUSY, WAIT_DONE, HOLDOFF.
REQ-021 IDLE: when pending != 0 and enc_busy == 0, SHALL grant the lowest-indexed pending bit (fixed priority, status highest), clear that bit, latch its index, and go to START.
REQ-022 START: SHALL drive the granted enc_start bit high for exactly this one cycle, load the timeout counter with START_TIMEOUT_CLKS, and go to WAIT_BUSY.
REQ-023 WAIT_BUSY: enc_busy high SHALL go to WAIT_DONE. Otherwise the counter SHALL decrement.
REQ-024 WAIT_BUSY timeout: when the counter reaches 0 with enc_busy low, SHALL set start_timeout_err, issue no done, load HOLDOFF_CLKS, and go to HOLDOFF.
REQ-025 WAIT_DONE: enc_busy low SHALL pulse done for 1 cycle with done_id = latched index, load HOLDOFF_CLKS, and go to HOLDOFF.
REQ-026 HOLDOFF: SHALL decrement to 0, then go to IDLE. Requests arriving meanwhile SHALL only accumulate in pending.
REQ-027 Latency: from req on an idle, non-busy system, enc_start SHALL assert exactly 2 cycles after req is sampled.
REQ-028 abort in any state SHALL clear pending (req in the same cycle is ignored).
REQ-029 abort in START, WAIT_BUSY, or WAIT_DONE SHALL additionally drive enc_enable low for exactly 1 cycle, suppress done, suppress enc_start, and go to HOLDOFF.
REQ-030 abort in IDLE or HOLDOFF SHALL not change state.
REQ-031 enc_enable SHALL otherwise equal enable delayed by one register.
REQ-032 enable low SHALL force: IDLE; pending = 0; enc_start = 0; done = 0; counters = 0. Requests SHALL be ignored.
REQ-033 clear_err SHALL clear start_timeout_err. A simultaneous timeout SHALL win (flag set).
REQ-034 Counter width SHALL be $clog2(max(HOLDOFF_CLKS, START_TIMEOUT_CLKS)+1) bits.

Reset
REQ-035 On reset_n low, the block SHALL asynchronously force: state IDLE; enc_start = 0; enc_enable = 0; done = 0; done_id = 0; pending = 0; active = 0; start_timeout_err = 0; counters = 0.
REQ-036 Reset mid-report SHALL drop the report with no done pulse.
REQ-037 After reset release, enc_enable SHALL rise 1 cycle after enable is sampled high.

Verification
REQ-038 Single report: req=5'b00001 with enc_busy model asserting 3 cycles after start for 50 cycles -> enc_start=5'b00001 two cycles after req; done with done_id=0 one cycle after busy falls; active low HOLDOFF_CLKS+1 cycles later.
REQ-039 Priority and queuing: req=5'b10110 in one cycle -> grants in order 1, 2, 4, each separated by ≥HOLDOFF_CLKS idle cycles; pending steps 10110→10100→10000→00000.
REQ-040 Timeout: req=5'b01000 with enc_busy held low -> start_timeout_err=1 START_TIMEOUT_CLKS+1 cycles after enc_start; no done. clear_err -> 0.
REQ-041 Abort in WAIT_DONE with pending=5'b00011 -> enc_enable low 1 cycle; pending=0; no done; HOLDOFF, then IDLE.
REQ-042 Set-wins collision: req[0] pulsed in the grant cycle of bit 0 -> pending[0]=1 afterwards; second status report issued after holdoff.
REQ-043 Async reset asserted in WAIT_DONE -> all outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/qic117_report_scheduler.sv
// QIC-117 report scheduler.
// Queues report requests, grants them one at a time in fixed priority
// (status first), starts the status encoder, and watches it through to
// completion. A timeout catches an encoder that never accepts a start.
// After every report a holdoff gap is enforced before the next grant.
module qic117_report_scheduler #(
    parameter int CLK_FREQ_HZ        = 200_000_000,
    parameter int HOLDOFF_US         = 100,
    parameter int START_TIMEOUT_CLKS = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [4:0] req,
    input  logic       abort,
    input  logic       clear_err,
    input  logic       enc_busy,
    output logic [4:0] enc_start,
    output logic       enc_enable,
    output logic       done,
    output logic [2:0] done_id,
    output logic [4:0] pending,
    output logic       active,
    output logic       start_timeout_err
);

    localparam int HOLDOFF_CLKS = (CLK_FREQ_HZ / 1_000_000) * HOLDOFF_US;
    localparam int CNT_MAX      = (HOLDOFF_CLKS > START_TIMEOUT_CLKS) ? HOLDOFF_CLKS : START_TIMEOUT_CLKS;
    localparam int CNT_W        = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CLKS);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(START_TIMEOUT_CLKS);
    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    // Index of the lowest set bit (bit 0 = status has top priority).
    function automatic logic [2:0] lowest_index(input logic [4:0] bits);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (bits[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // One-hot report select for a report index.
    function automatic logic [4:0] index_onehot(input logic [2:0] idx);
        logic [4:0] oh;
        case (idx)
            3'd0:    oh = 5'b00001;
            3'd1:    oh = 5'b00010;
            3'd2:    oh = 5'b00100;
            3'd3:    oh = 5'b01000;
            3'd4:    oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       idx_r, idx_s;
    logic [4:0]       pending_r, pending_s;
    logic [4:0]       grant_s;
    logic [4:0]       enc_start_r, start_s;
    logic             enc_enable_r, ena_s;
    logic             done_r, done_s;
    logic [2:0]       done_id_r, done_id_s;
    logic             active_r, active_s;
    logic             err_r, err_s;
    logic             timeout_s;

    // Next-state, counter, pending bitmap and output decode.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        grant_s   = 5'd0;
        start_s   = 5'd0;
        done_s    = 1'b0;
        done_id_s = done_id_r;
        ena_s     = enable;
        timeout_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // abort in IDLE only empties the queue, so no grant either
                if (!abort && (pending_r != 5'd0) && !enc_busy) begin
                    idx_s   = lowest_index(pending_r);
                    grant_s = index_onehot(lowest_index(pending_r));
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (abort) begin
                    ena_s   = 1'b0;
                    cnt_s   = HOLDOFF_LOAD;
                    state_s = ST_HOLDOFF;
                end else begin
                    start_s = index_onehot(idx_r);
                    cnt_s   = TIMEOUT_LOAD;
                    state_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (abort) begin
                    ena_s   = 1'b0;
                    cnt_s   = HOLDOFF_LOAD;
                    state_s = ST_HOLDOFF;
                end else if (enc_busy) begin
                    state_s = ST_WAIT_DONE;
                end else if (cnt_r == CNT_ZERO) begin
                    timeout_s = 1'b1;
                    cnt_s     = HOLDOFF_LOAD;
                    state_s   = ST_HOLDOFF;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_WAIT_DONE: begin
                if (abort) begin
                    ena_s   = 1'b0;
                    cnt_s   = HOLDOFF_LOAD;
                    state_s = ST_HOLDOFF;
                end else if (!enc_busy) begin
                    done_s    = 1'b1;
                    done_id_s = idx_r;
                    cnt_s     = HOLDOFF_LOAD;
                    state_s   = ST_HOLDOFF;
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase

        // a request landing on the bit being granted keeps it queued
        if (abort) begin
            pending_s = 5'd0;
        end else begin
            pending_s = (pending_r & ~grant_s) | req;
        end

        // leaving tape mode wipes everything except the sticky error
        if (!enable) begin
            state_s   = ST_IDLE;
            cnt_s     = CNT_ZERO;
            pending_s = 5'd0;
            start_s   = 5'd0;
            done_s    = 1'b0;
            timeout_s = 1'b0;
        end else begin
            state_s = state_s;
        end

        // a timeout in the same cycle as clear_err keeps the flag set
        if (timeout_s) begin
            err_s = 1'b1;
        end else if (clear_err) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end

        active_s = (state_s != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            idx_r        <= 3'd0;
            pending_r    <= 5'd0;
            enc_start_r  <= 5'd0;
            enc_enable_r <= 1'b0;
            done_r       <= 1'b0;
            done_id_r    <= 3'd0;
            active_r     <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            idx_r        <= idx_s;
            pending_r    <= pending_s;
            enc_start_r  <= start_s;
            enc_enable_r <= ena_s;
            done_r       <= done_s;
            done_id_r    <= done_id_s;
            active_r     <= active_s;
            err_r        <= err_s;
        end
    end

    assign enc_start         = enc_start_r;
    assign enc_enable        = enc_enable_r;
    assign done              = done_r;
    assign done_id           = done_id_r;
    assign pending           = pending_r;
    assign active            = active_r;
    assign start_timeout_err = err_r;

endmodule
